load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. Consumes the ALU result as the effective address, performs byte/half/word loads and stores over a req/ack data-memory port with variable latency, and stalls the pipeline while an access is outstanding. Returns sign- or zero-extended load data for writeback.

Parameters:
DATA_WIDTH, 32, data/address width (only 32 supported)
TIMEOUT_CYCLES, 255, max BUSY cycles waiting for MemAck_i before abort (1..255)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
ALUResult_i  input  DATA_WIDTH  effective byte address from ALU
WriteData_i  input  DATA_WIDTH  store data (rs2)
MemRead_i  input  1  load request
MemWrite_i  input  1  store request
Funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
Stall_o  output  1  hold upstream pipeline
ReadData_o  output  DATA_WIDTH  extended load result
ReadValid_o  output  1  one-cycle pulse, ReadData_o valid
AccessErr_o  output  1  one-cycle pulse: misaligned, illegal funct3, both read+write, or timeout
MemReq_o  output  1  memory request, held until ack
MemWe_o  output  1  1 = write
MemAddr_o  output  DATA_WIDTH  word address ({addr[31:2],2'b00})
MemWData_o  output  DATA_WIDTH  lane-replicated store data
MemBe_o  output  4  byte enables
MemRData_i  input  DATA_WIDTH  read word, valid with MemAck_i
MemAck_i  input  1  access complete

Behaviour:
- Clock clk_i; reset rst_i asynchronous, active-high. Reset: state IDLE, timeout counter 0, all outputs 0; reset mid-access drops MemReq_o immediately, no ack or pulse later.
- FSM states IDLE, BUSY, DONE.
- IDLE, MemRead_i|MemWrite_i high: validate combinationally. Illegal if both high; funct3 011/110/111; store funct3 100/101; H with addr[0]=1; W with addr[1:0]!=0. Illegal -> AccessErr_o pulses next cycle, no memory request, Stall_o never asserted, stay IDLE.
- Legal request: Stall_o=1 combinationally same cycle; latch addr, write data, funct3, read/write; -> BUSY.
- BUSY: MemReq_o=1, MemWe_o=store, MemAddr_o/MemWData_o/MemBe_o from latched values, constant until ack; Stall_o=1. Counter increments each BUSY cycle without ack.
- MemAck_i sampled high in BUSY: load -> ReadData_o registered from MemRData_i; -> DONE. MemReq_o low from DONE on.
- Timeout: counter reaches TIMEOUT_CYCLES without ack -> abort to DONE, AccessErr_o pulses in DONE, no ReadValid_o. Later late ack ignored.
- DONE (one cycle): Stall_o=0; ReadValid_o=1 for completed loads only; inputs ignored; -> IDLE. Pipeline advances at end of DONE.
- MemAck_i outside BUSY ignored. Counter cleared on entering BUSY.
- Latency: ack in first BUSY cycle -> Stall_o high 2 cycles, ReadValid_o 2 cycles after request.
- Byte enables (o=addr[1:0]): B/BU 4'b0001<<o; H/HU 4'b0011<<o; W 4'b1111. Same for loads and stores.
- Store data: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd. MemWData_o=0 for loads.
- Load extract: byte=MemRData_i[8*o+:8], half=MemRData_i[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
- ReadData_o holds its value until the next load completes or reset.

Test Plan:
- LW addr 0x100, MemRData_i=0xDEADBEEF, ack first BUSY cycle -> MemAddr_o=0x100, MemBe_o=1111, Stall_o high 2 cycles, ReadValid_o pulse, ReadData_o=0xDEADBEEF.
- LB addr 0x103, MemRData_i=0x80FF1234 -> MemBe_o=1000, ReadData_o=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SH addr 0x206, WriteData_i=0x1234ABCD -> MemWe_o=1, MemAddr_o=0x204, MemBe_o=1100, MemWData_o=0xABCDABCD, no ReadValid_o.
- LW addr 0x101; SH addr 0x001; MemRead_i=MemWrite_i=1; funct3=011 -> AccessErr_o one pulse each, MemReq_o never high, Stall_o stays 0.
- TIMEOUT_CYCLES=4, no ack -> MemReq_o high 4 cycles then low, AccessErr_o pulse, no ReadValid_o; later MemAck_i ignored.
- Assert rst_i while BUSY with MemReq_o=1 -> MemReq_o, Stall_o drop immediately; after release, new LW completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundle of pipeline-side and data-memory-side signals for the load/store unit.
//   slave  : the load/store unit view (takes ALU/pipeline inputs and memory
//            responses; drives stall, load result and the memory request).
//   master : the environment view (pipeline + data memory), the mirror image.
// Memory handshake: MemReq_o is raised with stable MemWe_o/MemAddr_o/MemWData_o/
// MemBe_o and held until the cycle in which MemAck_i is sampled high; that
// cycle completes the transfer (MemRData_i valid alongside MemAck_i for loads).
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ALUResult_i;
  logic [DATA_WIDTH-1:0] WriteData_i;
  logic                  MemRead_i;
  logic                  MemWrite_i;
  logic [2:0]            Funct3_i;
  logic                  Stall_o;
  logic [DATA_WIDTH-1:0] ReadData_o;
  logic                  ReadValid_o;
  logic                  AccessErr_o;
  logic                  MemReq_o;
  logic                  MemWe_o;
  logic [DATA_WIDTH-1:0] MemAddr_o;
  logic [DATA_WIDTH-1:0] MemWData_o;
  logic [3:0]            MemBe_o;
  logic [DATA_WIDTH-1:0] MemRData_i;
  logic                  MemAck_i;

  modport slave (
    input  ALUResult_i, WriteData_i, MemRead_i, MemWrite_i, Funct3_i,
    input  MemRData_i, MemAck_i,
    output Stall_o, ReadData_o, ReadValid_o, AccessErr_o,
    output MemReq_o, MemWe_o, MemAddr_o, MemWData_o, MemBe_o
  );

  modport master (
    output ALUResult_i, WriteData_i, MemRead_i, MemWrite_i, Funct3_i,
    output MemRData_i, MemAck_i,
    input  Stall_o, ReadData_o, ReadValid_o, AccessErr_o,
    input  MemReq_o, MemWe_o, MemAddr_o, MemWData_o, MemBe_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: memory-access stage after the ALU.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   bus       : load_store_unit_if.slave (pipeline request, stall, load result,
//               error pulse, and the req/ack data-memory port)
//   dbg_state : current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// A legal request in IDLE stalls the pipeline immediately, is latched, and is
// issued on the memory port from BUSY until ack or timeout. DONE lasts one
// cycle and releases the stall; ReadValid_o / AccessErr_o are registered pulses.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  load_store_unit_if.slave     bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state, state_next;
  logic [7:0]            cnt;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            f3_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  read_valid_q;
  logic                  access_err_q;

  // Request validation, evaluated on the live inputs while IDLE.
  logic req_in;
  logic illegal;
  always_comb begin
    illegal = 1'b0;
    req_in  = bus.MemRead_i | bus.MemWrite_i;
    case (bus.Funct3_i)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = bus.ALUResult_i[0];
      3'b010:         illegal = (bus.ALUResult_i[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (bus.MemWrite_i && bus.Funct3_i[2]) illegal = 1'b1;
    if (bus.MemRead_i && bus.MemWrite_i)   illegal = 1'b1;
  end

  logic accept;
  logic timeout_hit;
  assign accept      = (state == IDLE) && req_in && !illegal;
  assign timeout_hit = (state == BUSY) && !bus.MemAck_i && (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (bus.MemAck_i || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte lane helpers derived from the latched request.
  logic [1:0]            off;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] st_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;
  always_comb begin
    off = addr_q[1:0];
    case (f3_q[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    case (f3_q[1:0])
      2'b00:   st_data = {4{wdata_q[7:0]}};
      2'b01:   st_data = {2{wdata_q[15:0]}};
      default: st_data = wdata_q;
    endcase
    ld_byte = bus.MemRData_i[{off, 3'b000} +: 8];
    ld_half = bus.MemRData_i[{off[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.MemRData_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      read_valid_q <= 1'b0;
      access_err_q <= 1'b0;
      if (state == IDLE && req_in && illegal) access_err_q <= 1'b1;
      if (accept) begin
        cnt     <= '0;
        addr_q  <= bus.ALUResult_i;
        wdata_q <= bus.WriteData_i;
        f3_q    <= bus.Funct3_i;
        we_q    <= bus.MemWrite_i;
      end
      if (state == BUSY) begin
        if (bus.MemAck_i) begin
          if (!we_q) begin
            read_data_q  <= ld_data;
            read_valid_q <= 1'b1;
          end
        end else begin
          cnt <= cnt + 8'd1;
          if (timeout_hit) access_err_q <= 1'b1;
        end
      end
    end
  end

  logic busy;
  assign busy = (state == BUSY);

  assign bus.Stall_o     = busy || accept;
  assign bus.MemReq_o    = busy;
  assign bus.MemWe_o     = busy && we_q;
  assign bus.MemAddr_o   = busy ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign bus.MemWData_o  = (busy && we_q) ? st_data : '0;
  assign bus.MemBe_o     = busy ? be : 4'b0000;
  assign bus.ReadData_o  = read_data_q;
  assign bus.ReadValid_o = read_valid_q;
  assign bus.AccessErr_o = access_err_q;
  assign dbg_state       = state;

endmodule
